// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control path: load codes,
// sequencer states, trap causes and the base opcodes decode_logic also uses.
package core_ctrl_pkg;

    localparam logic [2:0] LD_NO      = 3'b000;
    localparam logic [2:0] LD_ALU     = 3'b001;
    localparam logic [2:0] LD_MEM     = 3'b010;
    localparam logic [2:0] LD_IMM     = 3'b011;
    localparam logic [2:0] LD_PC      = 3'b100;
    localparam logic [2:0] LD_PC_PIMM = 3'b101;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    // Nothing to load, nothing to store and no jump: the decoder did not recognise the word.
    function automatic logic is_illegal(input logic [2:0] ld_code,
                                        input logic       mem_wr,
                                        input logic       jmp);
        return (ld_code == LD_NO) && !mem_wr && !jmp;
    endfunction

    function automatic logic needs_mem(input logic [2:0] ld_code,
                                       input logic       mem_wr);
        return (ld_code == LD_MEM) || mem_wr;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive no-ack cycles of a pending memory request and flags the
// cycle that reaches LIMIT. Only built when MEM_TIMEOUT_EN is defined.
`ifdef MEM_TIMEOUT_EN
module mem_wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    input  logic ack,
    output logic expired
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    // Any cycle that is not a stalled wait restarts the count, so each new
    // FETCH/MEM entry begins from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (waiting && !ack) begin
            count <= count + W'(1);
        end else begin
            count <= '0;
        end
    end

    assign expired = waiting && !ack && (count == W'(LIMIT - 1));

endmodule
`endif

// File: rtl/instr_cycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// Define MEM_TIMEOUT_EN to trap after TIMEOUT_CYCLES unacknowledged wait cycles.
module instr_cycle_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ir,
    input  logic [2:0]       dec_ld_code,
    input  logic             dec_en_jmp,
    input  logic             dec_en_uncond_jmp,
    input  logic             dec_en_rel_reg_jmp,
    input  logic             dec_en_mem_wr,
    input  logic             branch_taken,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             rf_we,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t state;
    logic   take;
    logic   wb_pc_en;
    logic   wb_retire;
    logic   store_done;
    logic   timeout;

`ifdef MEM_TIMEOUT_EN
    logic waiting;
    logic wait_ack;

    assign waiting  = (state == S_FETCH) || (state == S_MEM);
    assign wait_ack = (state == S_FETCH) ? imem_ack : dmem_ack;

    mem_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .waiting (waiting),
        .ack     (wait_ack),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // A store retires in its ack cycle rather than passing through WB.
    assign store_done = (state == S_MEM) && dmem_we && dmem_ack;
    assign pc_en      = wb_pc_en | store_done;
    assign retire     = wb_retire | store_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ir         <= '0;
            take       <= 1'b0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            rf_we      <= 1'b0;
            wb_pc_en   <= 1'b0;
            wb_retire  <= 1'b0;
            pc_sel     <= 1'b0;
            trap       <= 1'b0;
            trap_cause <= CAUSE_NONE;
        end else begin
            rf_we     <= 1'b0;
            wb_pc_en  <= 1'b0;
            wb_retire <= 1'b0;
            pc_sel    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end else if (timeout) begin
                        imem_req   <= 1'b0;
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_TIMEOUT;
                        state      <= S_TRAP;
                    end
                end
                S_DECODE: begin
                    if (is_illegal(dec_ld_code, dec_en_mem_wr, dec_en_jmp)) begin
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_ILLEGAL;
                        state      <= S_TRAP;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    take <= branch_taken;
                    if (needs_mem(dec_ld_code, dec_en_mem_wr)) begin
                        dmem_req <= 1'b1;
                        dmem_we  <= dec_en_mem_wr;
                        state    <= S_MEM;
                    end else begin
                        rf_we     <= (dec_ld_code != LD_NO);
                        wb_pc_en  <= 1'b1;
                        wb_retire <= 1'b1;
                        pc_sel    <= dec_en_uncond_jmp | dec_en_rel_reg_jmp |
                                     (dec_en_jmp & branch_taken);
                        state     <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (dmem_we) begin
                            imem_req <= run;
                            state    <= run ? S_FETCH : S_IDLE;
                        end else begin
                            rf_we     <= (dec_ld_code != LD_NO);
                            wb_pc_en  <= 1'b1;
                            wb_retire <= 1'b1;
                            pc_sel    <= dec_en_uncond_jmp | dec_en_rel_reg_jmp |
                                         (dec_en_jmp & take);
                            state     <= S_WB;
                        end
                    end else if (timeout) begin
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_TIMEOUT;
                        state      <= S_TRAP;
                    end
                end
                S_WB: begin
                    imem_req <= run;
                    state    <= run ? S_FETCH : S_IDLE;
                end
                S_TRAP: begin
                    state <= S_TRAP;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_cycle_ctrl.sv
// Self-checking bench for instr_cycle_ctrl: directed vector table, random
// instruction stream against a transaction-level model, trap/reset sequences.
module tb_instr_cycle_ctrl;

    localparam int CW = 3;

    logic          clk;
    logic          rst_n;
    logic          run;
    logic          imem_req;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic [31:0]   ir;
    logic [2:0]    dec_ld_code;
    logic          dec_en_jmp;
    logic          dec_en_uncond_jmp;
    logic          dec_en_rel_reg_jmp;
    logic          dec_en_mem_wr;
    logic          branch_taken;
    logic          dmem_req;
    logic          dmem_we;
    logic          dmem_ack;
    logic          rf_we;
    logic          pc_en;
    logic          pc_sel;
    logic          retire;
    logic [CW-1:0] instret;
    logic          trap;
    logic [1:0]    trap_cause;

    int checks;
    int errors;
    int retired;

    typedef struct {
        logic [31:0] word;
        int          fw;
        int          mw;
        logic        bt;
        logic        ra;
        int          cyc;
        int          dmem;
        logic        we;
        logic        rf;
        logic        sel;
    } vec_t;

    typedef struct {
        int          cyc;
        int          nimem;
        int          ndmem;
        logic        we_seen;
        int          nrf;
        int          nret;
        logic        sel;
        logic        pcen;
        logic [31:0] ir_dec;
        logic        trapped;
        logic        done;
    } res_t;

    instr_cycle_ctrl #(
        .TIMEOUT_CYCLES (16),
        .CNT_W          (CW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .run                (run),
        .imem_req           (imem_req),
        .imem_ack           (imem_ack),
        .imem_rdata         (imem_rdata),
        .ir                 (ir),
        .dec_ld_code        (dec_ld_code),
        .dec_en_jmp         (dec_en_jmp),
        .dec_en_uncond_jmp  (dec_en_uncond_jmp),
        .dec_en_rel_reg_jmp (dec_en_rel_reg_jmp),
        .dec_en_mem_wr      (dec_en_mem_wr),
        .branch_taken       (branch_taken),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_ack           (dmem_ack),
        .rf_we              (rf_we),
        .pc_en              (pc_en),
        .pc_sel             (pc_sel),
        .retire             (retire),
        .instret            (instret),
        .trap               (trap),
        .trap_cause         (trap_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for decode_logic, driven from the DUT's instruction register.
    always_comb begin
        dec_ld_code        = 3'b000;
        dec_en_jmp         = 1'b0;
        dec_en_uncond_jmp  = 1'b0;
        dec_en_rel_reg_jmp = 1'b0;
        dec_en_mem_wr      = 1'b0;
        case (ir[6:0])
            7'b0010011, 7'b0110011: dec_ld_code = 3'b001;
            7'b0110111:             dec_ld_code = 3'b011;
            7'b0010111:             dec_ld_code = 3'b101;
            7'b0000011:             dec_ld_code = 3'b010;
            7'b0100011:             dec_en_mem_wr = 1'b1;
            7'b1100011:             dec_en_jmp = 1'b1;
            7'b1101111: begin
                dec_ld_code       = 3'b100;
                dec_en_jmp        = 1'b1;
                dec_en_uncond_jmp = 1'b1;
            end
            7'b1100111: begin
                dec_ld_code        = 3'b100;
                dec_en_jmp         = 1'b1;
                dec_en_rel_reg_jmp = 1'b1;
            end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Classes: 0 OP-IMM, 1 OP, 2 LUI, 3 AUIPC, 4 LOAD, 5 STORE, 6 BRANCH, 7 JAL, 8 JALR
    function automatic logic [6:0] class_opcode(input int cls);
        case (cls)
            0:       return 7'b0010011;
            1:       return 7'b0110011;
            2:       return 7'b0110111;
            3:       return 7'b0010111;
            4:       return 7'b0000011;
            5:       return 7'b0100011;
            6:       return 7'b1100011;
            7:       return 7'b1101111;
            default: return 7'b1100111;
        endcase
    endfunction

    // Whole-instruction expectation: fetch wait + decode + exec + optional memory + WB (not for stores).
    function automatic vec_t model(input int cls, input logic [31:0] word, input int fw,
                                   input int mw, input logic bt, input logic ra);
        vec_t v;
        logic is_ld, is_st, is_br;
        is_ld = (cls == 4);
        is_st = (cls == 5);
        is_br = (cls == 6);
        v.word = word;
        v.fw   = fw;
        v.mw   = mw;
        v.bt   = bt;
        v.ra   = ra;
        v.cyc  = (fw + 1) + 2 + ((is_ld || is_st) ? mw + 1 : 0) + (is_st ? 0 : 1);
        v.dmem = (is_ld || is_st) ? mw + 1 : 0;
        v.we   = is_st;
        v.rf   = !(is_st || is_br);
        v.sel  = (cls == 7) || (cls == 8) || (is_br && bt);
        return v;
    endfunction

    // Memory responder plus observer for one instruction; ends after retire or trap.
    task automatic run_instr(input vec_t v, output res_t r);
        int   fcnt;
        int   mcnt;
        int   w;
        logic acked;
        logic got_ir;
        r = '{default: 0};
        w = 0;
        while (!imem_req && w < 30) begin
            tick();
            w++;
        end
        if (!imem_req) begin
            chk("fetch_start", imem_req, 1);
            return;
        end
        fcnt = 0;
        mcnt = 0;
        acked = 1'b0;
        got_ir = 1'b0;
        branch_taken = v.bt;
        while (!r.done && r.cyc < 200) begin
            r.cyc++;
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            if (acked && !got_ir) begin
                r.ir_dec = ir;
                got_ir = 1'b1;
                run = v.ra;
            end
            if (imem_req) begin
                r.nimem++;
                if (fcnt == v.fw) begin
                    imem_ack = 1'b1;
                    imem_rdata = v.word;
                    acked = 1'b1;
                end
                fcnt++;
            end
            if (dmem_req) begin
                r.ndmem++;
                if (dmem_we) r.we_seen = 1'b1;
                if (mcnt == v.mw) dmem_ack = 1'b1;
                mcnt++;
            end
            #1;
            if (rf_we) r.nrf++;
            if (retire) begin
                r.nret++;
                r.sel = pc_sel;
                r.pcen = pc_en;
                r.done = 1'b1;
            end
            if (trap) begin
                r.trapped = 1'b1;
                r.done = 1'b1;
            end
            tick();
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        if (!r.done) chk("instr_done", r.done, 1);
    endtask

    task automatic apply(input vec_t v);
        res_t r;
        run_instr(v, r);
        chk("cycles", r.cyc, v.cyc);
        chk("imem_req_cycles", r.nimem, v.fw + 1);
        chk("dmem_req_cycles", r.ndmem, v.dmem);
        chk("dmem_we", r.we_seen, v.we);
        chk("rf_we_cycles", r.nrf, v.rf ? 1 : 0);
        chk("retire_pulses", r.nret, 1);
        chk("pc_en_at_retire", r.pcen, 1);
        chk("pc_sel", r.sel, v.sel);
        chk("ir_in_decode", r.ir_dec, v.word);
        chk("no_trap", r.trapped, 0);
        retired++;
        chk("instret", instret, retired % (1 << CW));
        if (!v.ra) begin
            for (int i = 0; i < 3; i++) begin
                chk("idle_no_fetch", imem_req, 0);
                tick();
            end
            run = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        retired = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[12];
        vec_t v;
        res_t r;
        int   n;
        logic [31:0] word;
        int   cls;

        checks = 0;
        errors = 0;
        retired = 0;
        run = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        imem_rdata = '0;
        branch_taken = 1'b0;

        //        word          fw  mw  bt    ra    cyc dmem we    rf    sel
        vt[0]  = '{32'h00500093, 0,  0, 1'b0, 1'b1,  4, 0, 1'b0, 1'b1, 1'b0};
        vt[1]  = '{32'h0000A103, 0,  3, 1'b0, 1'b1,  8, 4, 1'b0, 1'b1, 1'b0};
        vt[2]  = '{32'h0020A223, 0,  0, 1'b0, 1'b1,  4, 1, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{32'h00000463, 0,  0, 1'b1, 1'b1,  4, 0, 1'b0, 1'b0, 1'b1};
        vt[4]  = '{32'h00000463, 0,  0, 1'b0, 1'b1,  4, 0, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{32'h123452B7, 2,  0, 1'b0, 1'b1,  6, 0, 1'b0, 1'b1, 1'b0};
        vt[6]  = '{32'h008000EF, 0,  0, 1'b0, 1'b1,  4, 0, 1'b0, 1'b1, 1'b1};
        vt[7]  = '{32'h000080E7, 1,  0, 1'b1, 1'b1,  5, 0, 1'b0, 1'b1, 1'b1};
        vt[8]  = '{32'h0000A103, 1,  0, 1'b0, 1'b0,  6, 1, 1'b0, 1'b1, 1'b0};
        vt[9]  = '{32'h0020A223, 3,  2, 1'b0, 1'b0,  9, 3, 1'b1, 1'b0, 1'b0};
        vt[10] = '{32'h00500093, 15, 0, 1'b0, 1'b1, 19, 0, 1'b0, 1'b1, 1'b0};
        vt[11] = '{32'h00000517, 0,  0, 1'b1, 1'b1,  4, 0, 1'b0, 1'b1, 1'b0};

        // Reset state, then IDLE must hold while run is low.
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_retire", retire, 0);
        chk("rst_trap", trap, 0);
        chk("rst_trap_cause", trap_cause, 0);
        chk("rst_ir", ir, 0);
        chk("rst_instret", instret, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_run_low", imem_req, 0);
        end
        run = 1'b1;

        for (int i = 0; i < 12; i++) apply(vt[i]);

`ifndef MEM_TIMEOUT_EN
        apply(model(0, 32'h00A00113, 25, 0, 1'b0, 1'b1));
`endif

        for (int i = 0; i < 60; i++) begin
            cls = $urandom_range(0, 8);
            word = $urandom();
            word[6:0] = class_opcode(cls);
            v = model(cls, word, $urandom_range(0, 4), $urandom_range(0, 4),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            apply(v);
        end

        // Illegal word: trap after DECODE, then nothing more is fetched.
        v = '{32'h00000000, 1, 0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0};
        run_instr(v, r);
        chk("illegal_trap_seen", r.trapped, 1);
        chk("illegal_cycles", r.cyc, 4);
        chk("illegal_no_retire", r.nret, 0);
        chk("illegal_cause", trap_cause, 2'b01);
        for (int i = 0; i < 4; i++) begin
            chk("trap_no_fetch", imem_req, 0);
            chk("trap_sticky", trap, 1);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("trap_reset_flag", trap, 0);
        chk("trap_reset_cause", trap_cause, 0);
        chk("trap_reset_instret", instret, 0);
        tick();
        rst_n = 1'b1;
        retired = 0;

        // Reset mid-FETCH drops the request immediately; a late ack is ignored.
        run = 1'b1;
        n = 0;
        while (!imem_req && n < 10) begin
            tick();
            n++;
        end
        chk("mid_fetch_req", imem_req, 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("async_req_drop", imem_req, 0);
        run = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("late_ack_ir", ir, 0);
            chk("late_ack_req", imem_req, 0);
            chk("late_ack_retire", retire, 0);
        end
        imem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
        // Fetch never acknowledged: trap with cause 10 after 16 request cycles.
        do_reset();
        run = 1'b1;
        n = 0;
        while (!imem_req && n < 10) begin
            tick();
            n++;
        end
        n = 0;
        while (imem_req && n < 40) begin
            n++;
            tick();
        end
        chk("timeout_fetch_cycles", n, 16);
        chk("timeout_trap", trap, 1);
        chk("timeout_cause", trap_cause, 2'b10);
        tick();
        chk("timeout_no_refetch", imem_req, 0);
        do_reset();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_cycle_ctrl.md
Name: instr_cycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I core.
- Fetches an instruction word into an internal instruction register (IR) that drives decode_logic.
- Consumes decode_logic control outputs and steps the datapath through FETCH/DECODE/EXEC/MEM/WB.
- Issues instruction- and data-memory handshakes plus PC-update, register-file write and trap strobes.

Parameters:
- TIMEOUT_CYCLES, 16, consecutive no-ack cycles in FETCH or MEM before timeout trap (used only with MEM_TIMEOUT_EN).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- run  in  1  permit fetch of next instruction
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid
- imem_rdata  in  32  fetched word
- ir  out  32  instruction register, wired to decode_logic instr
- dec_ld_code  in  3  from decode_logic ld_code
- dec_en_jmp, dec_en_uncond_jmp, dec_en_rel_reg_jmp, dec_en_mem_wr  in  1 each  from decode_logic
- branch_taken  in  1  ALU compare result, valid in EXEC
- dmem_req  out  1  data access request
- dmem_we  out  1  1=store, 0=load; valid with dmem_req
- dmem_ack  in  1  data access complete
- rf_we  out  1  register-file write strobe
- pc_en  out  1  PC update strobe
- pc_sel  out  1  0=PC+4, 1=jump/branch target
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  CNT_W  retired-instruction count
- trap  out  1  sticky fault flag
- trap_cause  out  2  01 illegal, 10 timeout, 00 none

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Encoding is registered; outputs are Moore decodes of state plus the registered decode inputs.
- Reset (any time, including mid-access): state=IDLE, ir=0, instret=0, trap=0, trap_cause=00, all strobes 0. Any in-flight memory access is abandoned; a late ack is ignored.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH: imem_req=1 until imem_ack. On the ack cycle, ir<=imem_rdata and go to DECODE. imem_ack outside FETCH is ignored.
- DECODE: one cycle.
  - illegal = dec_ld_code==000 && !dec_en_mem_wr && !dec_en_jmp.
  - If illegal: go to TRAP with cause 01. Otherwise go to EXEC.
- EXEC: one cycle.
  - If dec_ld_code==010 (MEM_LD) or dec_en_mem_wr: go to MEM.
  - Otherwise go to WB.
  - branch_taken is sampled into an internal take flag here.
- MEM: dmem_req=1, dmem_we=dec_en_mem_wr, held until dmem_ack.
  - Load on ack: go to WB.
  - Store on ack: pc_en=1, pc_sel=0, retire=1, then FETCH if run else IDLE.
- WB: one cycle.
  - rf_we = (dec_ld_code!=000). The decoder's reg-write enable on branches is deliberately not used.
  - pc_en=1, pc_sel = dec_en_uncond_jmp | dec_en_rel_reg_jmp | (dec_en_jmp & take).
  - retire=1; then FETCH if run else IDLE.
- TRAP: terminal until reset. No requests, no strobes; trap=1.
- Latency with zero-wait memory: ALU/LUI/AUIPC/branch/jump 4 cycles, load 5, store 4.
- run is sampled only in IDLE, WB, and the store-completion cycle of MEM. Deasserting run never aborts an instruction in progress.
- instret increments on each retire and wraps at 2^CNT_W-1 -> 0.
- Simultaneous ack and reset: reset wins.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - Wait counter clears on entry to FETCH/MEM and counts each no-ack cycle.
  - Reaching TIMEOUT_CYCLES goes to TRAP with cause 10 and deasserts the request.
  - Ack on the same cycle as the limit completes normally.
- Undefined: waits indefinitely, no counter logic, cause 10 never produced.

Decomposition:
- Shared package core_ctrl_pkg:
  - ld_code constants (NO 000, ALU 001, MEM 010, IMM 011, PC 100, PC_PIMM 101)
  - state enum
  - trap_cause constants
  - opcode constants shared with decode_logic
- One natural sub-module: mem_wait_timer (wait counter/compare), instantiated only under MEM_TIMEOUT_EN.
- decode_logic is instantiated by the parent core, not inside this block.

Test Plan:
- addi x1,x0,5 (0x00500093), immediate acks, run=1 -> ir=0x00500093 in DECODE; rf_we=1, pc_en=1, pc_sel=0 in cycle 4; instret=1.
- lw x2,0(x1) (0x0000A103), dmem_ack delayed 3 cycles -> dmem_req held 4 cycles with dmem_we=0; rf_we in WB; total 8 cycles.
- sw x2,4(x1) (0x0020A223) -> dmem_we=1; rf_we never asserted; pc_en+retire on the ack cycle.
- beq x0,x0,8 (0x00000463), branch_taken=1 in EXEC -> WB pc_sel=1, rf_we=0. Repeat with branch_taken=0 -> pc_sel=0.
- Word 0x00000000 -> TRAP after DECODE, trap_cause=01, no further imem_req. rst_n pulse low -> IDLE, trap=0.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, imem_ack never asserted -> trap_cause=10 after 16 FETCH cycles. Also assert rst_n low mid-FETCH -> imem_req drops immediately (async).
